// File: rtl/relay_bit_decoder_if.sv
// rtl/relay_bit_decoder_if.sv - sample/strobe bundle between the relay line and its bit decoder
interface relay_bit_decoder_if #(
    parameter int WORD_W = 8
);
    logic              mode;
    logic              data_in;
    logic              receiving;
    logic              bit_valid;
    logic              bit_val;
    logic              bit_err;
    logic              data_out;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;

    modport master (
        output mode, data_in,
        input  receiving, bit_valid, bit_val, bit_err, data_out, word_out, word_valid
    );

    modport slave (
        input  mode, data_in,
        output receiving, bit_valid, bit_val, bit_err, data_out, word_out, word_valid
    );
endinterface

// File: rtl/relay_bit_decoder.sv
// rtl/relay_bit_decoder.sv - majority-vote oversampled bit decoder with held pulse and word assembly
module relay_bit_decoder #(
    parameter int WINDOW       = 64,
    parameter int HOLD_FAST    = 32,
    parameter int HOLD_SLOW    = 64,
    parameter int MIN_MARGIN   = 8,
    parameter int WORD_W       = 8,
    parameter int IDLE_WINDOWS = 4
) (
    input logic                clk,
    input logic                reset,
    relay_bit_decoder_if.slave bus
);
    localparam int CW   = $clog2(WINDOW + 1);
    localparam int HMAX = (HOLD_FAST > HOLD_SLOW) ? HOLD_FAST : HOLD_SLOW;
    localparam int HW   = $clog2(HMAX + 1);
    localparam int IW   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int SW   = $clog2(IDLE_WINDOWS + 1);

    localparam logic [CW-1:0] WIN_C      = CW'(WINDOW);
    localparam logic [CW:0]   WIN2_C     = (CW + 1)'(WINDOW);
    localparam logic [31:0]   MARGIN_C   = MIN_MARGIN;
    localparam logic [HW-1:0] HOLD_F_C   = HW'(HOLD_FAST);
    localparam logic [HW-1:0] HOLD_S_C   = HW'(HOLD_SLOW);
    localparam logic [IW-1:0] LAST_IDX_C = IW'(WORD_W - 1);
    localparam logic [SW-1:0] LAST_SIL_C = SW'(IDLE_WINDOWS - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RECV = 1'b1;

    logic [0:0]        r_state;
    logic [CW-1:0]     r_sample_cnt;
    logic [CW-1:0]     r_ones_cnt;
    logic [IW-1:0]     r_bit_idx;
    logic [SW-1:0]     r_silent_cnt;
    logic [HW-1:0]     r_hold_cnt;
    logic [WORD_W-1:0] r_shift;
    logic              r_receiving;
    logic              r_bit_valid;
    logic              r_bit_val;
    logic              r_bit_err;
    logic              r_data_out;
    logic [WORD_W-1:0] r_word_out;
    logic              r_word_valid;

    logic [CW-1:0]     w_cnt_nxt;
    logic [CW-1:0]     w_ones_nxt;
    logic [CW:0]       w_ones2;
    logic [CW:0]       w_margin;
    logic              w_done;
    logic              w_bit;
    logic              w_err;
    logic              w_silent;
    logic              w_timeout;
    logic              w_word_done;
    logic [WORD_W-1:0] w_word;

    // The sample presented in the completion cycle is folded into the ending window.
    always_comb begin
        w_cnt_nxt   = r_sample_cnt + CW'(1);
        w_ones_nxt  = r_ones_cnt + CW'(bus.data_in);
        w_done      = (r_state == S_RECV) && (w_cnt_nxt == WIN_C);
        w_ones2     = {w_ones_nxt, 1'b0};
        w_bit       = (w_ones2 > WIN2_C);
        w_margin    = w_bit ? (w_ones2 - WIN2_C) : (WIN2_C - w_ones2);
        w_err       = (32'(w_margin) < MARGIN_C);
        w_silent    = (w_ones_nxt == '0);
        w_timeout   = w_done && w_silent && (r_silent_cnt == LAST_SIL_C);
        w_word_done = w_done && (r_bit_idx == LAST_IDX_C);
        w_word      = r_shift;
        w_word[r_bit_idx] = w_bit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_sample_cnt <= '0;
            r_ones_cnt   <= '0;
            r_bit_idx    <= '0;
            r_silent_cnt <= '0;
            r_hold_cnt   <= '0;
            r_shift      <= '0;
            r_receiving  <= 1'b0;
            r_bit_valid  <= 1'b0;
            r_bit_val    <= 1'b0;
            r_bit_err    <= 1'b0;
            r_data_out   <= 1'b0;
            r_word_out   <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_bit_valid  <= 1'b0;
            r_bit_err    <= 1'b0;
            r_word_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.data_in) begin
                        r_state      <= S_RECV;
                        r_receiving  <= 1'b1;
                        r_sample_cnt <= CW'(1);
                        r_ones_cnt   <= CW'(1);
                    end
                end
                default: begin
                    if (w_done) begin
                        r_sample_cnt <= '0;
                        r_ones_cnt   <= '0;
                        r_bit_valid  <= 1'b1;
                        r_bit_val    <= w_bit;
                        r_bit_err    <= w_err;
                        if (w_word_done) begin
                            r_word_out   <= w_word;
                            r_word_valid <= 1'b1;
                            r_bit_idx    <= '0;
                            r_shift      <= '0;
                        end else begin
                            r_shift   <= w_word;
                            r_bit_idx <= r_bit_idx + IW'(1);
                        end
                        // A completed word still goes out; only the partial word is dropped.
                        if (w_timeout) begin
                            r_state      <= S_IDLE;
                            r_receiving  <= 1'b0;
                            r_silent_cnt <= '0;
                            r_bit_idx    <= '0;
                            r_shift      <= '0;
                        end else begin
                            r_silent_cnt <= w_silent ? (r_silent_cnt + SW'(1)) : '0;
                        end
                    end else begin
                        r_sample_cnt <= w_cnt_nxt;
                        r_ones_cnt   <= w_ones_nxt;
                    end
                end
            endcase

            // A new decision restarts the pulse rather than extending it.
            if (w_done) begin
                r_hold_cnt <= bus.mode ? HOLD_F_C : HOLD_S_C;
                r_data_out <= w_bit;
            end else if (r_hold_cnt != '0) begin
                r_hold_cnt <= r_hold_cnt - HW'(1);
                if (r_hold_cnt == HW'(1)) begin
                    r_data_out <= 1'b0;
                end
            end
        end
    end

    assign bus.receiving  = r_receiving;
    assign bus.bit_valid  = r_bit_valid;
    assign bus.bit_val    = r_bit_val;
    assign bus.bit_err    = r_bit_err;
    assign bus.data_out   = r_data_out;
    assign bus.word_out   = r_word_out;
    assign bus.word_valid = r_word_valid;
endmodule

// File: tb/tb_relay_bit_decoder.sv
// tb/tb_relay_bit_decoder.sv - scoreboard bench for relay_bit_decoder
module tb_relay_bit_decoder;
    localparam int WINDOW       = 64;
    localparam int HOLD_FAST    = 32;
    localparam int HOLD_SLOW    = 64;
    localparam int MIN_MARGIN   = 8;
    localparam int WORD_W       = 8;
    localparam int IDLE_WINDOWS = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rst_q = 1'b1;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    relay_bit_decoder_if #(.WORD_W(WORD_W)) bus ();

    relay_bit_decoder #(
        .WINDOW(WINDOW), .HOLD_FAST(HOLD_FAST), .HOLD_SLOW(HOLD_SLOW),
        .MIN_MARGIN(MIN_MARGIN), .WORD_W(WORD_W), .IDLE_WINDOWS(IDLE_WINDOWS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    typedef struct { int cyc; logic b; logic e; int hold; } bit_exp_t;
    typedef struct { int cyc; logic [WORD_W-1:0] w; } word_exp_t;

    bit_exp_t  bq[$];
    word_exp_t wq[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: a window is a list of samples, a word a list of decided bits.
    bit   m_active = 1'b0;
    logic m_win[$];
    logic m_bits[$];
    int   m_silent = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_active = 1'b0;
        m_win.delete();
        m_bits.delete();
        m_silent = 0;
    endfunction

    function automatic void model_feed(input logic b, input logic md);
        int ones;
        int diff;
        bit_exp_t be;
        word_exp_t we;
        if (!m_active) begin
            if (b) begin
                m_active = 1'b1;
                m_win.delete();
                m_win.push_back(b);
            end
            return;
        end
        m_win.push_back(b);
        if (m_win.size() == WINDOW) begin
            ones = 0;
            foreach (m_win[i]) ones += int'(m_win[i]);
            diff = 2 * ones - WINDOW;
            if (diff < 0) diff = -diff;
            be.cyc  = cyc;
            be.b    = (2 * ones > WINDOW);
            be.e    = (diff < MIN_MARGIN);
            be.hold = md ? HOLD_FAST : HOLD_SLOW;
            bq.push_back(be);
            m_bits.push_back(be.b);
            if (m_bits.size() == WORD_W) begin
                we.cyc = cyc;
                we.w   = '0;
                foreach (m_bits[i]) we.w[i] = m_bits[i];
                wq.push_back(we);
                m_bits.delete();
            end
            m_silent = (ones == 0) ? m_silent + 1 : 0;
            if (m_silent == IDLE_WINDOWS) begin
                m_active = 1'b0;
                m_silent = 0;
                m_bits.delete();
            end
            m_win.delete();
        end
    endfunction

    task automatic drive(input logic b);
        bus.data_in = b;
        @(posedge clk);
        #1;
        model_feed(b, bus.mode);
    endtask

    // Sends one window with exactly k ones (at least one, led by a '1', when starting from idle).
    task automatic send_window(input int k);
        int need;
        int start;
        int r;
        logic b;
        need  = k;
        start = 0;
        if (!m_active) begin
            if (need == 0) need = 1;
            drive(1'b1);
            need--;
            start = 1;
        end
        for (int i = start; i < WINDOW; i++) begin
            r = WINDOW - i;
            b = ($urandom_range(r - 1, 0) < need);
            if (b) need--;
            drive(b);
        end
    endtask

    task automatic send_bit(input logic b);
        send_window(b ? int'($urandom_range(WINDOW, 40)) : int'($urandom_range(24, 1)));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.data_in = 1'($urandom);
        @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;
    endtask

    logic do_bit = 1'b0;
    int   do_until = 0;
    bit_exp_t  mb;
    word_exp_t mw;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_q) begin
                check("reset_outputs",
                      {bus.receiving, bus.bit_valid, bus.bit_val, bus.bit_err,
                       bus.data_out, bus.word_valid, bus.word_out}, '0);
                do_until = 0;
            end else begin
                if (bus.bit_valid) begin
                    if (bq.size() == 0) begin
                        check("bit_unexpected", 1, 0);
                    end else begin
                        mb = bq.pop_front();
                        check("bit_cycle", cyc, mb.cyc);
                        check("bit_val", bus.bit_val, mb.b);
                        check("bit_err", bus.bit_err, mb.e);
                        do_bit   = mb.b;
                        do_until = cyc + mb.hold;
                    end
                end else if (bq.size() > 0 && bq[0].cyc <= cyc) begin
                    check("bit_missing", cyc, bq[0].cyc);
                    void'(bq.pop_front());
                end
                if (bus.word_valid) begin
                    check("word_with_bit", bus.bit_valid, 1);
                    if (wq.size() == 0) begin
                        check("word_unexpected", 1, 0);
                    end else begin
                        mw = wq.pop_front();
                        check("word_cycle", cyc, mw.cyc);
                        check("word_out", bus.word_out, mw.w);
                    end
                end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
                    check("word_missing", cyc, wq[0].cyc);
                    void'(wq.pop_front());
                end
                check("data_out", bus.data_out, (cyc < do_until) ? do_bit : 1'b0);
                check("receiving", bus.receiving, m_active);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [7:0] pat;

    initial begin
        bus.mode    = 1'b0;
        bus.data_in = 1'b0;
        reset       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        reset  = 1'b0;

        repeat (100) drive(1'b0);

        bus.mode = 1'b0;
        send_window(64);
        send_window(32);
        send_window(36);
        send_window(35);
        repeat (4) send_bit(1'($urandom));

        bus.mode = 1'b1;
        pat = 8'b0100_1101;
        for (int i = 0; i < 8; i++) send_bit(pat[i]);

        bus.mode = 1'b0;
        repeat (3) send_bit(1'($urandom));
        repeat (IDLE_WINDOWS) send_window(0);
        repeat (20) drive(1'b0);
        for (int i = 0; i < WORD_W; i++) send_bit(1'($urandom));

        bus.mode = 1'b0;
        send_window(64);
        repeat (39) drive(1'($urandom));
        do_reset();
        repeat (5) drive(1'b0);
        for (int i = 0; i < WORD_W; i++) send_bit(1'($urandom));

        repeat (70) begin
            if ($urandom_range(29, 0) == 0) do_reset();
            if (!m_active && $urandom_range(3, 0) == 0) repeat ($urandom_range(20, 0)) drive(1'b0);
            bus.mode = 1'($urandom);
            case ($urandom_range(4, 0))
                0:       send_window(0);
                1:       send_window(int'($urandom_range(36, 28)));
                default: send_window(int'($urandom_range(WINDOW, 0)));
            endcase
        end

        if (m_active) repeat (IDLE_WINDOWS) send_window(0);
        repeat (80) drive(1'b0);

        check("bits_drained", bq.size(), 0);
        check("words_drained", wq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
